// File: rtl/bus_slave_port.sv
// Slave endpoint of the serial system bus: deserialises address/write data into a local
// memory and serialises read words back on tx_data with a valid/ready handshake.
module bus_slave_port #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic master_valid,
    input  logic master_ready,
    input  logic rx_address,
    input  logic rx_data,
    input  logic write_en,
    input  logic read_en,
    output logic tx_data,
    output logic slave_valid,
    output logic slave_ready
);

    localparam int unsigned MaxW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int unsigned CntW = $clog2(MaxW) + 1;
    localparam logic [CntW-1:0] AddrLast = CntW'(ADDR_WIDTH - 1);
    localparam logic [CntW-1:0] DataLast = CntW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRxAddr,
        StRxData,
        StWrite,
        StRead,
        StTxData
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   tx_sh_q, tx_sh_d;
    logic                    is_wr_q, is_wr_d;
    logic                    slave_ready_q, slave_ready_d;
    logic                    slave_valid_q, slave_valid_d;
    logic                    mem_we;

    logic [DATA_WIDTH-1:0]   mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0]   rdata_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        tx_sh_d       = tx_sh_q;
        is_wr_d       = is_wr_q;
        slave_ready_d = slave_ready_q;
        slave_valid_d = slave_valid_q;
        mem_we        = 1'b0;

        unique case (state_q)
            StIdle: begin
                slave_ready_d = 1'b1;
                if (slave_ready_q && master_valid && (write_en ^ read_en)) begin
                    addr_d        = {rx_address, addr_q[ADDR_WIDTH-1:1]};
                    is_wr_d       = write_en;
                    cnt_d         = CntW'(1);
                    slave_ready_d = 1'b0;
                    state_d       = StRxAddr;
                end
            end
            StRxAddr: begin
                if (master_valid) begin
                    // LSB-first stream: shift in at the top so bit 0 lands last-shifted
                    addr_d = {rx_address, addr_q[ADDR_WIDTH-1:1]};
                    if (cnt_q == AddrLast) begin
                        cnt_d   = '0;
                        state_d = is_wr_q ? StRxData : StRead;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StRxData: begin
                if (master_valid) begin
                    wdata_d = {rx_data, wdata_q[DATA_WIDTH-1:1]};
                    if (cnt_q == DataLast) begin
                        cnt_d   = '0;
                        state_d = StWrite;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StWrite: begin
                mem_we        = 1'b1;
                slave_ready_d = 1'b1;
                state_d       = StIdle;
            end
            StRead: begin
                // Registered read port: first cycle captures the word, second presents it
                if (cnt_q == '0) begin
                    cnt_d = CntW'(1);
                end else begin
                    cnt_d         = '0;
                    tx_sh_d       = rdata_q;
                    slave_valid_d = 1'b1;
                    state_d       = StTxData;
                end
            end
            StTxData: begin
                if (slave_valid_q && master_ready) begin
                    if (cnt_q == DataLast) begin
                        cnt_d         = '0;
                        tx_sh_d       = '0;
                        slave_valid_d = 1'b0;
                        slave_ready_d = 1'b1;
                        state_d       = StIdle;
                    end else begin
                        cnt_d   = cnt_q + CntW'(1);
                        tx_sh_d = tx_sh_q >> 1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            tx_sh_q       <= '0;
            is_wr_q       <= 1'b0;
            slave_ready_q <= 1'b0;
            slave_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            tx_sh_q       <= tx_sh_d;
            is_wr_q       <= is_wr_d;
            slave_ready_q <= slave_ready_d;
            slave_valid_q <= slave_valid_d;
        end
    end

    // Memory keeps its contents across reset
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[addr_q] <= wdata_q;
        end
        if (state_q == StRead) begin
            rdata_q <= mem_q[addr_q];
        end
    end

    assign tx_data     = tx_sh_q[0];
    assign slave_valid = slave_valid_q;
    assign slave_ready = slave_ready_q;

endmodule

// File: tb/tb_bus_slave_port.sv
// Directed self-checking bench for bus_slave_port (ADDR_WIDTH=12, DATA_WIDTH=8).
module tb_bus_slave_port;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst, master_valid, master_ready, rx_address, rx_data, write_en, read_en;
    logic tx_data, slave_valid, slave_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_slave_port #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .master_valid(master_valid),
        .master_ready(master_ready),
        .rx_address  (rx_address),
        .rx_data     (rx_data),
        .write_en    (write_en),
        .read_en     (read_en),
        .tx_data     (tx_data),
        .slave_valid (slave_valid),
        .slave_ready (slave_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_txn(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int lat;
        lat          = 0;
        master_valid = 1'b1;
        write_en     = 1'b1;
        read_en      = 1'b0;
        rx_address   = a[0];
        tick();
        write_en = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k < AW) rx_address = a[k];
            else if (k < AW + DW) rx_data = d[k-AW];
            tick();
            if (slave_ready === 1'b1) begin
                lat = k;
                break;
            end
        end
        master_valid = 1'b0;
        chk({tag, "_ready_low_cycles"}, 32'(lat), 32'd20);
    endtask

    task automatic read_txn(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        int vlat;
        logic [DW-1:0] word;
        vlat         = 0;
        word         = '0;
        master_valid = 1'b1;
        read_en      = 1'b1;
        write_en     = 1'b0;
        rx_address   = a[0];
        tick();
        read_en = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k < AW) rx_address = a[k];
            else master_valid = 1'b0;
            tick();
            if (slave_valid === 1'b1) begin
                vlat = k;
                break;
            end
        end
        master_valid = 1'b0;
        chk({tag, "_valid_latency"}, 32'(vlat), 32'd13);
        master_ready = 1'b1;
        for (int b = 0; b < DW; b++) begin
            word[b] = tx_data;
            tick();
        end
        master_ready = 1'b0;
        chk({tag, "_word"}, 32'(word), 32'(exp));
        chk({tag, "_valid_after"}, 32'(slave_valid), 32'd0);
        chk({tag, "_ready_after"}, 32'(slave_ready), 32'd1);
        chk({tag, "_tx_after"}, 32'(tx_data), 32'd0);
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] word;
        int vlat;

        rst          = 1'b1;
        master_valid = 1'b0;
        master_ready = 1'b0;
        rx_address   = 1'b0;
        rx_data      = 1'b0;
        write_en     = 1'b0;
        read_en      = 1'b0;

        // 1. Reset
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_ready", 32'(slave_ready), 32'd0);
            chk("rst_valid", 32'(slave_valid), 32'd0);
            chk("rst_tx", 32'(tx_data), 32'd0);
        end
        rst = 1'b0;
        tick();
        chk("rst_release_ready", 32'(slave_ready), 32'd1);

        // 2. Write 0xA5 to 0x123, then 3. read it back-to-back
        write_txn("wr_a5", 12'h123, 8'hA5);
        chk("wr_a5_ready", 32'(slave_ready), 32'd1);
        read_txn("rd_a5", 12'h123, 8'hA5);

        // Boundary address and a second pattern
        write_txn("wr_fff", 12'hFFF, 8'h3C);
        read_txn("rd_fff", 12'hFFF, 8'h3C);
        read_txn("rd_a5_again", 12'h123, 8'hA5);

        // 4. Stalls on both streams
        a            = 12'h123;
        word         = '0;
        vlat         = 0;
        master_valid = 1'b1;
        read_en      = 1'b1;
        rx_address   = a[0];
        tick();
        read_en = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            rx_address = a[k];
            tick();
        end
        master_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rx_address = ~a[5];
            tick();
        end
        master_valid = 1'b1;
        for (int k = 5; k < 12; k++) begin
            rx_address = a[k];
            tick();
        end
        master_valid = 1'b0;
        for (int k = 15; k <= 40; k++) begin
            tick();
            if (slave_valid === 1'b1) begin
                vlat = k;
                break;
            end
        end
        chk("stall_valid_latency", 32'(vlat), 32'd16);
        master_ready = 1'b1;
        for (int b = 0; b < DW; b++) begin
            if (b == 3) begin
                master_ready = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    tick();
                    chk("stall_hold_tx", 32'(tx_data), 32'd0);
                    chk("stall_hold_valid", 32'(slave_valid), 32'd1);
                end
                master_ready = 1'b1;
            end
            word[b] = tx_data;
            tick();
        end
        master_ready = 1'b0;
        chk("stall_word", 32'(word), 32'hA5);
        chk("stall_ready_after", 32'(slave_ready), 32'd1);

        // 5. Illegal starts
        master_valid = 1'b1;
        write_en     = 1'b1;
        read_en      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("illegal_both_ready", 32'(slave_ready), 32'd1);
        end
        write_en = 1'b0;
        read_en  = 1'b0;
        tick();
        chk("illegal_none_ready", 32'(slave_ready), 32'd1);
        master_valid = 1'b0;
        tick();
        read_txn("rd_after_illegal", 12'h123, 8'hA5);

        // 6. Reset in the middle of a write
        a            = 12'h123;
        word         = 8'h3C;
        master_valid = 1'b1;
        write_en     = 1'b1;
        rx_address   = a[0];
        tick();
        write_en = 1'b0;
        for (int k = 1; k < AW + 5; k++) begin
            if (k < AW) rx_address = a[k];
            else rx_data = word[k-AW];
            tick();
        end
        master_valid = 1'b0;
        rst          = 1'b1;
        tick();
        chk("midrst_ready", 32'(slave_ready), 32'd0);
        chk("midrst_valid", 32'(slave_valid), 32'd0);
        rst = 1'b0;
        tick();
        chk("midrst_release_ready", 32'(slave_ready), 32'd1);
        read_txn("rd_after_midrst", 12'h123, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
